four_bit_out_buffer: RTL

FOUR_BIT_OUT_BUFFER -- requirements
Module: four_bit_out_buffer

---
 rtl/four_bit_out_buffer.sv | 104 ++++++++++
 1 files changed

// File: rtl/four_bit_out_buffer.sv
// rtl/four_bit_out_buffer.sv - CPU output-port FIFO with halt-drain sequencing
module four_bit_out_buffer #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] OUT_in,
    input  logic       OUT_wr,
    input  logic       HLT_in,
    input  logic       READY,
    output logic [3:0] DATA,
    output logic       VALID,
    output logic       FULL,
    output logic       EMPTY,
    output logic [4:0] COUNT,
    output logic       OVF,
    output logic       DONE
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      mem_q [DEPTH];
    logic [3:0]      mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [4:0]      count_q, count_d;
    logic            ovf_q, ovf_d;

    logic            empty;
    logic            full;
    logic            pop;
    logic            wr_acc;
    logic            wr_drop;

    always_comb begin
        empty   = (count_q == 5'd0);
        full    = (count_q == 5'(DEPTH));
        pop     = !empty && READY;
        // A pop at the same edge frees the slot the write needs, even when full
        wr_acc  = (state_q == ST_RUN) && OUT_wr && (!full || pop);
        wr_drop = (state_q == ST_RUN) && OUT_wr && full && !pop;

        mem_d = mem_q;
        if (wr_acc) begin
            mem_d[wr_ptr_q] = OUT_in;
        end

        wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop    ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + {4'b0000, wr_acc} - {4'b0000, pop};
        ovf_d    = ovf_q || wr_drop;

        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (HLT_in) begin
                    state_d = (count_d == 5'd0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (count_d == 5'd0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_RUN;
        endcase

        EMPTY = empty;
        FULL  = full;
        VALID = !empty;
        DATA  = empty ? 4'b0000 : mem_q[rd_ptr_q];
        COUNT = count_q;
        OVF   = ovf_q;
        DONE  = (state_q == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 5'd0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Array contents stay hidden behind VALID, so they need no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule
